sub_serial: RTL and testbench
=============================

SUB_SERIAL -- requirements
Module: sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width in bits; legal range 1..16.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, request to begin one subtraction.
REQ-005 SHALL have port a, input, WIDTH, minuend.
REQ-006 SHALL have port b, input, WIDTH, subtrahend.
REQ-007 SHALL have port bin, input, 1, borrow-in.
REQ-008 SHALL have port d, output, WIDTH, difference, registered.
REQ-009 SHALL have port bout, output, 1, borrow-out, registered.
REQ-010 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse marking d/bout valid for a new result.

Function
REQ-012 SHALL compute d = (a - b - bin) mod 2^WIDTH and bout = 1 iff a < b + bin (unsigned).
REQ-013 SHALL use a single 1-bit full-subtractor stage: diff = x ^ y ^ br, br_next = (~x & y) | (~x & br) | (y & br); one bit per cycle, LSB first.
REQ-014 SHALL implement states IDLE, RUN, FIN.
REQ-015 IDLE: start=1 at an edge latches a, b, bin into internal registers, clears bit counter, enters RUN; start=0 stays IDLE.
REQ-016 RUN: each edge processes bit[counter], writes the difference bit into the shift/result register, updates the internal borrow, increments counter.
REQ-017 RUN: the edge that processes bit WIDTH-1 loads d and bout, enters FIN.
REQ-018 FIN: done=1 for exactly that one cycle; next edge returns to IDLE, or, if start=1, latches new operands and enters RUN (back-to-back).
REQ-019 Latency: start accepted at edge E0 -> done high in the cycle after edge E0+WIDTH; throughput one result per WIDTH+1 cycles.
REQ-020 busy SHALL be 1 in RUN, 0 in IDLE and FIN.
REQ-021 start while in RUN SHALL be ignored; latched operands SHALL not change mid-operation.
REQ-022 Changes on a, b, bin outside the accept edge SHALL not affect the result.
REQ-023 d and bout SHALL hold the last result unchanged until the next RUN->FIN edge; they SHALL not show partial results.
REQ-024 Bit counter SHALL be wide enough for WIDTH-1 and SHALL not wrap within an operation.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force state IDLE, d=0, bout=0, busy=0, done=0, counter=0, internal borrow=0.
REQ-026 Reset asserted during RUN SHALL abort the operation with no done pulse; first start after rst_n rises SHALL operate normally.
REQ-027 start sampled high on the first edge after rst_n deasserts SHALL be accepted.

Verification
REQ-028 WIDTH=4, a=9, b=3, bin=0, start pulse -> busy 4 cycles, done pulse, d=6, bout=0.
REQ-029 a=3, b=9, bin=0 -> d=0xA, bout=1; a=0, b=0, bin=1 -> d=0xF, bout=1; a=15, b=15, bin=1 -> d=0xF, bout=1.
REQ-030 start held high continuously with a=5,b=2 then a=7,b=7 -> back-to-back results d=3 then d=0, one done pulse per WIDTH+1 cycles, no lost/duplicate operation.
REQ-031 start re-pulsed and a/b changed during RUN -> ignored, result matches operands latched at accept.
REQ-032 rst_n low for one cycle mid-RUN -> outputs 0 immediately, no done, next operation (a=8,b=1) -> d=7, bout=0.
REQ-033 Exhaustive sweep all a, b, bin for WIDTH=4 against reference model of REQ-012; repeat spot check with WIDTH=1 and WIDTH=8.

Source files
------------

// File: rtl/sub_serial.sv
// sub_serial: bit-serial unsigned subtractor, d = a - b - bin.
// One full-subtractor stage is reused for WIDTH cycles, LSB first.
//
// Ports:
//   clk    - clock, rising-edge active
//   rst_n  - asynchronous active-low reset
//   start  - begin one subtraction (sampled in IDLE and FIN only)
//   a, b   - minuend / subtrahend, latched on the accept edge
//   bin    - borrow-in, latched on the accept edge
//   d      - difference, registered, updated only when a result completes
//   bout   - borrow-out, registered alongside d
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when d/bout carry a new result
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit processed per edge
// FIN   | result valid, done pulse; start here chains the next operation
module sub_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    // Counter needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             x;
    logic             y;
    logic             diff;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             last;

    // Operands shift right each RUN edge, so the current bit is always at [0].
    // The result fills from the top so the final bit lands it fully aligned.
    always_comb begin
        x       = opa[0];
        y       = opb[0];
        diff    = x ^ y ^ br;
        br_nxt  = (~x & y) | (~x & br) | (y & br);
        res_nxt = res >> 1;
        res_nxt[WIDTH-1] = diff;
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            d     <= '0;
            bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        br    <= bin;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    opa <= opa >> 1;
                    opb <= opb >> 1;
                    br  <= br_nxt;
                    res <= res_nxt;
                    if (last) begin
                        d     <= res_nxt;
                        bout  <= br_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: three instances (WIDTH 4, 1, 8) share
// operand buses and reset; each has its own start line. Expected results come
// from plain integer arithmetic on the operands.
module tb_sub_serial;

    logic        clk;
    logic        rst_n;
    logic [15:0] a_bus;
    logic [15:0] b_bus;
    logic        bin_s;
    logic [2:0]  start_v;   // [0]: WIDTH=4, [1]: WIDTH=1, [2]: WIDTH=8

    logic [3:0]  d4;
    logic [0:0]  d1;
    logic [7:0]  d8;
    logic [2:0]  bout_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;

    int          checks;
    int          errors;
    logic [15:0] prev_d [3];
    logic        prev_b [3];

    sub_serial #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a(a_bus[3:0]), .b(b_bus[3:0]), .bin(bin_s),
        .d(d4), .bout(bout_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    sub_serial #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a(a_bus[0:0]), .b(b_bus[0:0]), .bin(bin_s),
        .d(d1), .bout(bout_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    sub_serial #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .bin(bin_s),
        .d(d8), .bout(bout_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idx_of(int w);
        if (w == 4) return 0;
        if (w == 1) return 1;
        return 2;
    endfunction

    function automatic logic [15:0] d_of(int k);
        if (k == 0) return {12'd0, d4};
        if (k == 1) return {15'd0, d1};
        return {8'd0, d8};
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One subtraction on the instance of width w. When scramble is set, the
    // operand buses and start are randomised while the operation runs.
    task automatic op(int w, logic [15:0] av, logic [15:0] bv, logic bi, bit scramble);
        int          k;
        int          mask;
        int          ai;
        int          bi_int;
        logic [15:0] exp_d;
        logic        exp_b;
        k      = idx_of(w);
        mask   = (1 << w) - 1;
        ai     = int'(av) & mask;
        bi_int = int'(bv) & mask;
        exp_d  = 16'((ai - bi_int - int'(bi)) & mask);
        exp_b  = (ai < bi_int + int'(bi));

        @(negedge clk);
        a_bus      = av;
        b_bus      = bv;
        bin_s      = bi;
        start_v    = 3'b000;
        start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v = 3'b000;
        check("busy_accept", 16'(busy_v[k]), 16'd1);
        check("done_accept", 16'(done_v[k]), 16'd0);
        if (scramble) begin
            a_bus = 16'($urandom);
            b_bus = 16'($urandom);
            bin_s = 1'($urandom);
        end
        for (int i = 1; i <= w; i++) begin
            @(posedge clk);
            #1;
            if (i < w) begin
                check("busy_run", 16'(busy_v[k]), 16'd1);
                check("done_run", 16'(done_v[k]), 16'd0);
                check("d_hold", d_of(k), prev_d[k]);
                check("bout_hold", 16'(bout_v[k]), 16'(prev_b[k]));
                if (scramble) begin
                    a_bus      = 16'($urandom);
                    b_bus      = 16'($urandom);
                    bin_s      = 1'($urandom);
                    start_v[k] = 1'($urandom);
                end
            end else begin
                start_v = 3'b000;
                check("done_fin", 16'(done_v[k]), 16'd1);
                check("busy_fin", 16'(busy_v[k]), 16'd0);
                check("d_result", d_of(k), exp_d);
                check("bout_result", 16'(bout_v[k]), 16'(exp_b));
            end
        end
        @(posedge clk);
        #1;
        check("done_after", 16'(done_v[k]), 16'd0);
        check("busy_after", 16'(busy_v[k]), 16'd0);
        prev_d[k] = exp_d;
        prev_b[k] = exp_b;
    endtask

    initial begin
        int done_cnt;
        logic exp_busy;
        logic exp_done;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        a_bus   = '0;
        b_bus   = '0;
        bin_s   = 1'b0;
        start_v = 3'b000;
        for (int k = 0; k < 3; k++) begin
            prev_d[k] = '0;
            prev_b[k] = 1'b0;
        end

        #3;
        check("rst_d4", d_of(0), 16'd0);
        check("rst_bout", 16'(bout_v), 16'd0);
        check("rst_busy", 16'(busy_v), 16'd0);
        check("rst_done", 16'(done_v), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed examples.
        op(4, 16'd9, 16'd3, 1'b0, 1'b0);
        op(4, 16'd3, 16'd9, 1'b0, 1'b0);
        op(4, 16'd0, 16'd0, 1'b1, 1'b0);
        op(4, 16'd15, 16'd15, 1'b1, 1'b0);
        // Mid-run start pulses and operand changes must not leak in.
        op(4, 16'd12, 16'd5, 1'b1, 1'b1);
        op(4, 16'd6, 16'd6, 1'b0, 1'b1);

        // Back-to-back with start held high: 5-2 then 7-7.
        @(negedge clk);
        a_bus   = 16'd5;
        b_bus   = 16'd2;
        bin_s   = 1'b0;
        start_v = 3'b001;
        @(posedge clk);
        #1;
        a_bus    = 16'd7;
        b_bus    = 16'd7;
        done_cnt = 0;
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk);
            #1;
            exp_done = (i == 4) || (i == 9);
            exp_busy = (i <= 3) || (i >= 5 && i <= 8);
            if (i == 5) start_v = 3'b000;
            if (done_v[0]) done_cnt++;
            check("b2b_done", 16'(done_v[0]), 16'(exp_done));
            check("b2b_busy", 16'(busy_v[0]), 16'(exp_busy));
            if (i == 4) begin
                check("b2b_d1", d_of(0), 16'd3);
                check("b2b_bout1", 16'(bout_v[0]), 16'd0);
            end
            if (i == 9) begin
                check("b2b_d2", d_of(0), 16'd0);
                check("b2b_bout2", 16'(bout_v[0]), 16'd0);
            end
        end
        check("b2b_count", 16'(done_cnt), 16'd2);
        prev_d[0] = 16'd0;
        prev_b[0] = 1'b0;

        // Give d a nonzero value so the asynchronous clear is visible.
        op(4, 16'd9, 16'd3, 1'b0, 1'b0);

        // Reset in the middle of an operation.
        @(negedge clk);
        a_bus   = 16'd3;
        b_bus   = 16'd1;
        bin_s   = 1'b0;
        start_v = 3'b001;
        @(posedge clk);
        #1;
        start_v = 3'b000;
        @(posedge clk);
        #1;
        check("mid_busy_pre", 16'(busy_v[0]), 16'd1);
        rst_n = 1'b0;
        #1;
        check("async_d", d_of(0), 16'd0);
        check("async_bout", 16'(bout_v[0]), 16'd0);
        check("async_busy", 16'(busy_v[0]), 16'd0);
        check("async_done", 16'(done_v[0]), 16'd0);
        @(posedge clk);
        #1;
        check("rst_hold_done", 16'(done_v[0]), 16'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            prev_d[k] = '0;
            prev_b[k] = 1'b0;
        end
        // Accepted on the first edge after release.
        op(4, 16'd8, 16'd1, 1'b0, 1'b0);

        // Exhaustive WIDTH=4 sweep with mid-run disturbance.
        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int bi = 0; bi < 2; bi++)
                    op(4, 16'(av), 16'(bv), 1'(bi), 1'b1);

        // WIDTH=1 is small enough to cover fully.
        for (int av = 0; av < 2; av++)
            for (int bv = 0; bv < 2; bv++)
                for (int bi = 0; bi < 2; bi++)
                    op(1, 16'(av), 16'(bv), 1'(bi), 1'b1);

        // WIDTH=8 corners and random spot checks.
        op(8, 16'd0, 16'd0, 1'b1, 1'b0);
        op(8, 16'd255, 16'd255, 1'b1, 1'b0);
        op(8, 16'd200, 16'd55, 1'b0, 1'b0);
        op(8, 16'd55, 16'd200, 1'b1, 1'b1);
        for (int n = 0; n < 40; n++)
            op(8, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
